// File: rtl/tetris_input_pkg.sv
// Shared definitions for the PS/2 Tetris command decoder: command codes,
// Set 2 scancode constants, decoder state encoding and the key lookup.
package tetris_input_pkg;

  localparam int CMD_W    = 3;
  localparam int NUM_CMDS = 7;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROT_CW    = 3'd3,
    CMD_ROT_CCW   = 3'd4,
    CMD_SOFT_DROP = 3'd5,
    CMD_HARD_DROP = 3'd6,
    CMD_PAUSE     = 3'd7
  } cmd_e;

  // Prefix / control bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  // Controller housekeeping bytes that never start a key sequence
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Game keys (extended keys follow an E0 prefix)
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // E0
  localparam logic [7:0] SC_RIGHT = 8'h74;  // E0
  localparam logic [7:0] SC_UP    = 8'h75;  // E0
  localparam logic [7:0] SC_DOWN  = 8'h72;  // E0
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  // Bytes following E1 in the Pause/Break make sequence
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_e;

  // Map a scancode to a game command; ext selects the E0-prefixed table.
  function automatic cmd_e lookup_cmd(input logic ext, input logic [7:0] code);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  cmd = CMD_LEFT;
        SC_RIGHT: cmd = CMD_RIGHT;
        SC_UP:    cmd = CMD_ROT_CW;
        SC_DOWN:  cmd = CMD_SOFT_DROP;
        default:  cmd = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_X:     cmd = CMD_ROT_CW;
        SC_Z:     cmd = CMD_ROT_CCW;
        SC_SPACE: cmd = CMD_HARD_DROP;
        SC_P:     cmd = CMD_PAUSE;
        default:  cmd = CMD_NONE;
      endcase
    end
    return cmd;
  endfunction

  // Housekeeping bytes that leave the idle decoder untouched.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK)  || (code == SC_RESEND) ||
           (code == SC_ECHO)   || (code == SC_ERR0) || (code == SC_ERR1);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO for game commands. Pop is ignored when empty;
// a push on full is accepted only if a pop frees a slot in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  // Show-ahead head; forced to 0 when empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  // Accept/advance decisions and next pointer/count values
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-2 depth: pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port
  // NOTE: storage has no reset; emptiness is tracked by count_q alone, which keeps it RAM-mappable.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_game_cmd_decoder.sv
// PS/2 Set 2 scancode decoder for Tetris controls. Decodes make/break/E0/E1
// sequences, tracks held keys, and queues game commands for the processor.
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes
// of a key that is already held.
module ps2_game_cmd_decoder
  import tetris_input_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          ps2_key_pressed,
  input  logic [7:0]                    ps2_key_data,
  input  logic                          cmd_rd,
  output logic                          cmd_valid,
  output logic [CMD_W-1:0]              cmd_data,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic [NUM_CMDS-1:0]           key_held,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The force to IDLE happens as the counter steps onto TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  dec_state_e          state_q, state_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [2:0]          skip_q, skip_d;
  logic [NUM_CMDS-1:0] key_held_q, key_held_d;
  logic                overflow_q, overflow_d;

  cmd_e                dec_cmd;
  logic                is_make, is_brk;
  logic [2:0]          key_idx;
  logic                push;
  logic [CMD_W-1:0]    push_data;
  logic                fifo_full, fifo_empty;
  logic                pop_ok;

  // Decode FSM, timeout counter and key-held update
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    skip_d     = skip_q;
    key_held_d = key_held_q;
    dec_cmd    = CMD_NONE;
    is_make    = 1'b0;
    is_brk     = 1'b0;
    key_idx    = '0;
    push       = 1'b0;
    push_data  = '0;

    if (ps2_key_pressed) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == SC_E0)      state_d = ST_EXT;
          else if (ps2_key_data == SC_F0) state_d = ST_BRK;
          else if (ps2_key_data == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else if (!is_ignored(ps2_key_data)) begin
            dec_cmd = lookup_cmd(1'b0, ps2_key_data);
            is_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_key_data == SC_F0) state_d = ST_EXT_BRK;
          else begin
            dec_cmd = lookup_cmd(1'b1, ps2_key_data);
            is_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          dec_cmd = lookup_cmd(1'b0, ps2_key_data);
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          dec_cmd = lookup_cmd(1'b1, ps2_key_data);
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q >= TO_LAST) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (dec_cmd != CMD_NONE) begin
      key_idx = 3'(dec_cmd) - 3'd1;
      if (is_make) begin
        key_held_d[key_idx] = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        push = !key_held_q[key_idx];
`else
        push = 1'b1;
`endif
        push_data = 3'(dec_cmd);
      end else if (is_brk) begin
        key_held_d[key_idx] = 1'b0;
      end
    end
  end

  // Sticky overflow: a dropped push sets it, and setting beats clearing.
  always_comb begin
    pop_ok     = cmd_rd && !fifo_empty;
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (push && fifo_full && !pop_ok) overflow_d = 1'b1;
  end

  // Decoder state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      skip_q     <= '0;
      key_held_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      skip_q     <= skip_d;
      key_held_q <= key_held_d;
      overflow_q <= overflow_d;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (cmd_rd),
    .pop_data  (cmd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (cmd_count)
  );

  assign cmd_valid = !fifo_empty;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_game_cmd_decoder.sv
// Directed self-checking bench for ps2_game_cmd_decoder. The timeout is
// shortened so the idle-gap scenarios stay within a short run.
module tb_ps2_game_cmd_decoder;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       cmd_rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_data;
  logic [3:0] cmd_count;
  logic [6:0] key_held;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ps2_game_cmd_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .cmd_rd          (cmd_rd),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_count       (cmd_count),
    .key_held        (key_held),
    .overflow        (overflow),
    .ovf_clr         (ovf_clr)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe with optional pop / overflow-clear in the same cycle;
  // returns on the following falling edge, when results are visible.
  task automatic send_ctl(input logic [7:0] b, input logic rd, input logic clr);
    @(negedge clock);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    cmd_rd          = rd;
    ovf_clr         = clr;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    cmd_rd          = 1'b0;
    ovf_clr         = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_ctl(b, 1'b0, 1'b0);
  endtask

  task automatic pop();
    @(negedge clock);
    cmd_rd = 1'b1;
    @(negedge clock);
    cmd_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Bounded drain back to empty.
  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && cmd_valid; i++) pop();
    check("drain_empty", int'(cmd_valid), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    resetn = 1'b0;
    idle(2);
    check({tag, "_valid"}, int'(cmd_valid), 0);
    check({tag, "_data"},  int'(cmd_data),  0);
    check({tag, "_count"}, int'(cmd_count), 0);
    check({tag, "_held"},  int'(key_held),  0);
    check({tag, "_ovf"},   int'(overflow),  0);
    resetn = 1'b1;
    idle(1);
  endtask

  logic [7:0] fill_codes [8] = '{8'h22, 8'h1A, 8'h29, 8'h4D, 8'h22, 8'h1A, 8'h29, 8'h4D};
  int         after_pp   [8] = '{4, 6, 7, 3, 4, 6, 7, 7};
  logic [7:0] pause_tail [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    do_reset("rst");

    // 1: hard drop make then break
    send(8'h29);
    check("t1_valid", int'(cmd_valid), 1);
    check("t1_data",  int'(cmd_data),  6);
    check("t1_count", int'(cmd_count), 1);
    check("t1_held",  int'(key_held),  'h20);
    send(8'hF0); send(8'h29);
    check("t1_brk_held",  int'(key_held),  0);
    check("t1_brk_count", int'(cmd_count), 1);
    pop();
    check("t1_pop_valid", int'(cmd_valid), 0);

    // housekeeping bytes in IDLE are ignored
    send(8'hAA); send(8'hFA);
    check("ign_count", int'(cmd_count), 0);

    // 2: extended arrows queue in order
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h75);
    check("t2_count", int'(cmd_count), 3);
    check("t2_held",  int'(key_held),  'h07);
    check("t2_head0", int'(cmd_data),  1);
    pop(); check("t2_head1", int'(cmd_data), 2);
    pop(); check("t2_head2", int'(cmd_data), 3);
    pop(); check("t2_empty", int'(cmd_valid), 0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_brk_held", int'(key_held), 0);

    // either ROT_CW key's break clears the shared bit
    send(8'h22);
    check("cw_held", int'(key_held), 'h04);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("cw_brk_held", int'(key_held), 0);
    drain();

    // 3: nine auto-repeat makes without pops
    for (int i = 0; i < 9; i++) send(8'h29);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t3_count", int'(cmd_count), 1);
    check("t3_ovf",   int'(overflow),  0);
`else
    check("t3_count", int'(cmd_count), 8);
    check("t3_ovf",   int'(overflow),  1);
    pulse_clr();
    check("t3_clr",   int'(overflow),  0);
`endif
    drain();
    send(8'hF0); send(8'h29);

    // 4: fill with released keys, then push+pop on full
    for (int i = 0; i < 8; i++) begin
      send(fill_codes[i]); send(8'hF0); send(fill_codes[i]);
    end
    check("t4_full", int'(cmd_count), 8);
    check("t4_head", int'(cmd_data),  3);
    send_ctl(8'h4D, 1'b1, 1'b0);
    check("t4_pp_count", int'(cmd_count), 8);
    check("t4_pp_head",  int'(cmd_data),  4);
    check("t4_pp_ovf",   int'(overflow),  0);
    send(8'h29);
    check("t4_drop_ovf",   int'(overflow),  1);
    check("t4_drop_count", int'(cmd_count), 8);
    pulse_clr();
    check("t4_clr", int'(overflow), 0);
    send_ctl(8'h22, 1'b0, 1'b1);
    check("t4_set_wins", int'(overflow), 1);
    check("t4_held", int'(key_held), 'h64);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_order%0d", i), int'(cmd_data), after_pp[i]);
      pop();
    end
    check("t4_empty", int'(cmd_valid), 0);

    // 5: timeout after prefix discards it
    do_reset("rst5");
    send(8'hE0);
    idle(TIMEOUT + 5);
    send(8'h6B);
    check("t5_to_count", int'(cmd_count), 0);
    check("t5_to_held",  int'(key_held),  0);
    // gap just under the timeout keeps the prefix
    send(8'hE0);
    idle(TIMEOUT - 10);
    send(8'h6B);
    check("t5_ok_count", int'(cmd_count), 1);
    check("t5_ok_data",  int'(cmd_data),  1);
    drain();
    send(8'hE0); send(8'hF0); send(8'h6B);
    // Pause sequence bytes are swallowed, then Z decodes normally
    send(8'hE1);
    for (int i = 0; i < 7; i++) send(pause_tail[i]);
    check("t5_skip_count", int'(cmd_count), 0);
    send(8'h1A);
    check("t5_z_count", int'(cmd_count), 1);
    check("t5_z_data",  int'(cmd_data),  4);
    check("t5_z_held",  int'(key_held),  'h08);

    // 6: reset mid-sequence
    send(8'h29);
    send(8'hE0); send(8'hF0);
    do_reset("rst6");
    send(8'h72);
    check("t6_count", int'(cmd_count), 0);
    check("t6_held",  int'(key_held),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
